count_arbiter_2ch: RTL and testbench
====================================

// Module: count_arbiter_2ch
// PURPOSE
//   Shares one loadable WIDTH-bit up-counter between two requesters, each timing an interval.
//   The block arbitrates round-robin and loads the winner's start value into the counter.
//   It counts up to TERM, then signals completion to the owner.
//   It sits in front of the loadable-counter datapath as its sequencer/arbiter; all outputs are registered.
// PARAMETERS
//   WIDTH  4               counter and start-value width
//   TERM   {WIDTH{1'b1}}   terminal count; an interval ends when count == TERM
// PORTS
//   clk     in   1      rising-edge clock; the only clock
//   rst     in   1      asynchronous, active-low reset
//   req0    in   1      requester 0 wants the counter (level; hold until gnt0)
//   data0   in   WIDTH  requester 0 start value, sampled on the granting edge
//   req1    in   1      requester 1 wants the counter (level; hold until gnt1)
//   data1   in   WIDTH  requester 1 start value, sampled on the granting edge
//   abort   in   1      terminate the current interval without completion
//   gnt0    out  1      counter owned by requester 0
//   gnt1    out  1      counter owned by requester 1
//   count   out  WIDTH  current counter value
//   busy    out  1      state != IDLE
//   done0   out  1      1-cycle pulse: requester 0 interval complete
//   done1   out  1      1-cycle pulse: requester 1 interval complete
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; gnt*, done*, busy = 0; count = 0; rr pointer favours req0.
//   FSM states: IDLE, RUN, DONE.
//   IDLE:
//     - No req: stay; count holds.
//     - Any req at edge k: pick winner; after edge k, state=RUN, gnt_w=1, count=data_w.
//     - Only one req: that requester wins.
//     - Both req: winner = requester not served last (rr pointer); pointer updates on each grant.
//   RUN:
//     - count == TERM at edge: next state DONE; count holds TERM.
//     - abort=1 at edge: next state IDLE; gnt dropped; count=0; no done. abort has priority over TERM.
//     - Otherwise count <= count+1 (WIDTH bits; cannot wrap, since TERM is reached first).
//     - RUN lasts TERM-data_w+1 cycles. data_w == TERM gives exactly 1 RUN cycle.
//   DONE:
//     - done_w=1 and gnt_w=0 for exactly one cycle, then IDLE.
//     - abort is ignored in DONE.
//   Grant spacing: minimum 1 IDLE cycle between the last RUN cycle of one grant and the next grant.
//   Input sampling:
//     - req/data are sampled only in IDLE.
//     - req changes during RUN/DONE are ignored.
//     - A requester still asserting req in IDLE after its done is re-granted (subject to rr).
//   Exclusivity: gnt0 & gnt1 is never 1; done0 & done1 is never 1.
//   Reset asserted mid-RUN: outputs clear immediately (asynchronously); no done is issued.
// TESTING
//   1 Reset: rst=0 mid-RUN -> gnt0/gnt1/busy/done*=0 and count=0 before the next clk edge.
//   2 Single: req0=1, data0=4'hC -> gnt0 next cycle; count C,D,E,F over 4 RUN cycles;
//     then done0=1 for 1 cycle with gnt0=0; then IDLE.
//   3 Contention: after reset, req0=req1=1, data0=4'hE, data1=4'hD -> req0 served first (2 RUN cycles).
//     Then req1 (3 RUN cycles). With both held high, grants alternate 0,1,0,1.
//   4 Boundary: data1=4'hF -> 1 RUN cycle with count=F, then done1.
//   5 Abort: data0=4'h1, abort=1 when count=3 -> IDLE next cycle; count=0; done0 never pulses.
//     abort asserted in DONE -> done pulse unaffected.
//   6 Late req: req1 rises during req0's RUN -> not granted until IDLE; gnt1 follows req0's DONE cycle + 1 IDLE cycle.

Source files
------------

// File: rtl/count_arbiter_2ch.sv
// count_arbiter_2ch: round-robin arbiter sharing one loadable up-counter between two interval timers
module count_arbiter_2ch #(
  parameter int                 WIDTH = 4,
  parameter logic [WIDTH-1:0]   TERM  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic             abort,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done0,
  output logic             done1
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic             r_own, w_own, w_win, w_any, w_grant, w_term;
  logic [WIDTH-1:0] r_count, w_count;
  logic             r_gnt0, r_gnt1, r_busy, r_done0, r_done1;
  logic             w_gnt0, w_gnt1, w_busy, w_done0, w_done1;

  // r_own doubles as the round-robin pointer: it only changes on a grant, so it names the last served
  assign w_any   = req0 | req1;
  assign w_win   = (req0 & req1) ? ~r_own : req1;
  assign w_grant = (r_state == IDLE) & w_any;
  assign w_term  = r_count == TERM;

  // state register; reset leaves the pointer favouring requester 0
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_own   <= 1'b1;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_own   <= w_own;
      r_count <= w_count;
    end

  // next state: abort beats terminal count, DONE always falls back to IDLE
  always_comb
    w_next = (r_state == IDLE) ? (w_any ? RUN : IDLE) :
             (r_state == RUN)  ? (abort ? IDLE : (w_term ? DONE : RUN)) : IDLE;

  // next values of the registered outputs, derived from the upcoming state
  always_comb begin
    w_own   = w_grant ? w_win : r_own;
    w_count = (r_state == IDLE) ? (w_grant ? (w_win ? data1 : data0) : r_count) :
              (r_state == RUN)  ? (abort ? '0 : (w_term ? r_count : r_count + 1'b1)) : r_count;
    w_gnt0  = (w_next == RUN)  & ~w_own;
    w_gnt1  = (w_next == RUN)  &  w_own;
    w_done0 = (w_next == DONE) & ~w_own;
    w_done1 = (w_next == DONE) &  w_own;
    w_busy  = w_next != IDLE;
  end

  // output registers so every port comes straight from a flop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_busy  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else begin
      r_gnt0  <= w_gnt0;
      r_gnt1  <= w_gnt1;
      r_busy  <= w_busy;
      r_done0 <= w_done0;
      r_done1 <= w_done1;
    end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign busy  = r_busy;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign count = r_count;
endmodule

// File: tb/tb_count_arbiter_2ch.sv
// tb_count_arbiter_2ch: vector table with scoreboard queue plus hand-written reset checks
module tb_count_arbiter_2ch;
  logic       clk = 1'b0, rst = 1'b0, req0 = 1'b0, req1 = 1'b0, abort = 1'b0;
  logic [3:0] data0 = '0, data1 = '0;
  logic       gnt0, gnt1, busy, done0, done1;
  logic [3:0] count;

  typedef struct {
    logic       rb;
    logic       r0;
    logic [3:0] d0;
    logic       r1;
    logic [3:0] d1;
    logic       ab;
    logic [8:0] exp;
  } vec_t;

  // output flag groups {gnt0,gnt1,busy,done0,done1}
  localparam logic [4:0] G0 = 5'b10100, G1 = 5'b01100, D0 = 5'b00110, D1 = 5'b00101, ID = 5'b00000;

  vec_t       tbl[$];
  logic [8:0] sb[$];
  int         n_vec = 0, n_bad = 0;

  count_arbiter_2ch dut (
    .clk(clk), .rst(rst), .req0(req0), .data0(data0), .req1(req1), .data1(data1), .abort(abort),
    .gnt0(gnt0), .gnt1(gnt1), .count(count), .busy(busy), .done0(done0), .done1(done1)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {gnt0, gnt1, busy, done0, done1, count};
  endfunction

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got g0g1 b d0d1 cnt=%b, expected %b", nm, act, exp);
    end
  endtask

  task automatic add(input logic rb, input logic r0, input logic [3:0] d0, input logic r1,
                     input logic [3:0] d1, input logic ab, input logic [4:0] f, input logic [3:0] c);
    tbl.push_back('{rb, r0, d0, r1, d1, ab, {f, c}});
  endtask

  initial begin
    @(posedge clk); #1;
    check("reset_state", outs(), 9'h0);
    rst = 1'b1;
    req0 = 1'b1; data0 = 4'hC;
    @(posedge clk); #1;
    check("pre_async_reset_grant", outs(), {G0, 4'hC});
    req0 = 1'b0;
    #3 rst = 1'b0;
    #1 check("async_reset_mid_run", outs(), 9'h0);
    @(posedge clk); #1;
    check("reset_held", outs(), 9'h0);
    rst = 1'b1;
    // single requester, C..F then done0
    add(0, 1, 4'hC, 0, 4'h0, 0, G0, 4'hC);
    add(0, 0, 4'hC, 0, 4'h0, 0, G0, 4'hD);
    add(0, 0, 4'hC, 0, 4'h0, 0, G0, 4'hE);
    add(0, 0, 4'hC, 0, 4'h0, 0, G0, 4'hF);
    add(0, 0, 4'hC, 0, 4'h0, 0, D0, 4'hF);
    add(0, 0, 4'hC, 0, 4'h0, 0, ID, 4'hF);
    add(0, 0, 4'hC, 0, 4'h0, 0, ID, 4'hF);
    // contention after reset: 0 first, then alternating
    add(1, 1, 4'hE, 1, 4'hD, 0, G0, 4'hE);
    add(0, 1, 4'hE, 1, 4'hD, 0, G0, 4'hF);
    add(0, 1, 4'hE, 1, 4'hD, 0, D0, 4'hF);
    add(0, 1, 4'hE, 1, 4'hD, 0, ID, 4'hF);
    add(0, 1, 4'hE, 1, 4'hD, 0, G1, 4'hD);
    add(0, 1, 4'hE, 1, 4'hD, 0, G1, 4'hE);
    add(0, 1, 4'hE, 1, 4'hD, 0, G1, 4'hF);
    add(0, 1, 4'hE, 1, 4'hD, 0, D1, 4'hF);
    add(0, 1, 4'hE, 1, 4'hD, 0, ID, 4'hF);
    add(0, 1, 4'hE, 1, 4'hD, 0, G0, 4'hE);
    add(0, 1, 4'hE, 1, 4'hD, 0, G0, 4'hF);
    add(0, 1, 4'hE, 1, 4'hD, 0, D0, 4'hF);
    add(0, 1, 4'hE, 1, 4'hD, 0, ID, 4'hF);
    add(0, 1, 4'hE, 1, 4'hD, 0, G1, 4'hD);
    add(0, 0, 4'hE, 0, 4'hD, 0, G1, 4'hE);
    add(0, 0, 4'hE, 0, 4'hD, 0, G1, 4'hF);
    add(0, 0, 4'hE, 0, 4'hD, 0, D1, 4'hF);
    add(0, 0, 4'hE, 0, 4'hD, 0, ID, 4'hF);
    // start value equal to TERM: single RUN cycle
    add(0, 0, 4'h0, 1, 4'hF, 0, G1, 4'hF);
    add(0, 0, 4'h0, 0, 4'h0, 0, D1, 4'hF);
    add(0, 0, 4'h0, 0, 4'h0, 0, ID, 4'hF);
    // abort at count 3
    add(0, 1, 4'h1, 0, 4'h0, 0, G0, 4'h1);
    add(0, 0, 4'h1, 0, 4'h0, 0, G0, 4'h2);
    add(0, 0, 4'h1, 0, 4'h0, 0, G0, 4'h3);
    add(0, 0, 4'h1, 0, 4'h0, 1, ID, 4'h0);
    add(0, 0, 4'h1, 0, 4'h0, 0, ID, 4'h0);
    // abort in DONE is ignored
    add(0, 1, 4'hF, 0, 4'h0, 0, G0, 4'hF);
    add(0, 0, 4'hF, 0, 4'h0, 0, D0, 4'hF);
    add(0, 0, 4'hF, 0, 4'h0, 1, ID, 4'hF);
    add(0, 0, 4'hF, 0, 4'h0, 0, ID, 4'hF);
    // abort wins over terminal count
    add(0, 1, 4'hF, 0, 4'h0, 0, G0, 4'hF);
    add(0, 0, 4'hF, 0, 4'h0, 1, ID, 4'h0);
    add(0, 0, 4'hF, 0, 4'h0, 0, ID, 4'h0);
    // late req1 during req0 RUN waits for DONE plus one IDLE cycle
    add(0, 1, 4'hD, 0, 4'h0, 0, G0, 4'hD);
    add(0, 0, 4'hD, 1, 4'hA, 0, G0, 4'hE);
    add(0, 0, 4'hD, 1, 4'hA, 0, G0, 4'hF);
    add(0, 0, 4'hD, 1, 4'hA, 0, D0, 4'hF);
    add(0, 0, 4'hD, 1, 4'hA, 0, ID, 4'hF);
    add(0, 0, 4'hD, 1, 4'hA, 0, G1, 4'hA);
    add(0, 0, 4'hD, 0, 4'hA, 0, G1, 4'hB);
    add(0, 0, 4'hD, 0, 4'hA, 0, G1, 4'hC);
    add(0, 0, 4'hD, 0, 4'hA, 0, G1, 4'hD);
    add(0, 0, 4'hD, 0, 4'hA, 0, G1, 4'hE);
    add(0, 0, 4'hD, 0, 4'hA, 0, G1, 4'hF);
    add(0, 0, 4'hD, 0, 4'hA, 0, D1, 4'hF);
    add(0, 0, 4'hD, 0, 4'hA, 0, ID, 4'hF);
    foreach (tbl[i]) begin
      if (tbl[i].rb) begin
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
      end
      req0 = tbl[i].r0; data0 = tbl[i].d0;
      req1 = tbl[i].r1; data1 = tbl[i].d1;
      abort = tbl[i].ab;
      sb.push_back(tbl[i].exp);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), outs(), sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
